// File: rtl/icap_s6_reg_access.sv
// Single-word ICAP configuration-register access engine for Spartan-6.
// Expands one read/write request into sync, Type-1 header, data/readback, desync.
module icap_s6_reg_access #(
  parameter bit BIT_SWAP = 1'b0,
  parameter int NOOP_PAD = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [5:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        icap_ce,
  output logic        icap_write,
  output logic [15:0] icap_i,
  input  logic [15:0] icap_o,
  input  logic        icap_busy
);

  localparam int CW = 10;

  typedef enum logic [3:0] {
    IDLE, SYNC, HDR, WDATA, RPAD, RCE_OFF, RMODE, RWAIT,
    RBACK_CE, RBACK_WR, DESYNC, DONE
  } state_e;

  function automatic logic [15:0] swap16(input logic [15:0] w);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      r[b]     = w[7-b];
      r[8+b]   = w[15-b];
    end
    return r;
  endfunction

  function automatic logic [15:0] sync_word(input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = 16'hFFFF;
      2'd1:    w = 16'hAA99;
      2'd2:    w = 16'h5566;
      default: w = 16'h2000;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] desync_word(input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = 16'h30A1;
      2'd1:    w = 16'h000D;
      default: w = 16'h2000;
    endcase
    return w;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [5:0]    addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          icap_ce_q, icap_ce_d;
  logic          icap_write_q, icap_write_d;
  logic [15:0]   icap_i_q, icap_i_d;
  logic [15:0]   word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        state_d = SYNC;
        cnt_d   = '0;
        wr_d    = req_write;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      SYNC: if (cnt_q == CW'(3)) begin
        state_d = HDR;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CW'(1);
      HDR: begin
        state_d = wr_q ? WDATA : RPAD;
        cnt_d   = '0;
      end
      WDATA: begin
        state_d = DESYNC;
        cnt_d   = '0;
      end
      RPAD: if (cnt_q == CW'(NOOP_PAD - 1)) state_d = RCE_OFF;
            else cnt_d = cnt_q + CW'(1);
      RCE_OFF: state_d = RMODE;
      RMODE: begin
        state_d = RWAIT;
        cnt_d   = '0;
      end
      // First RWAIT cycle only presents CE; data is sampled from the second on.
      RWAIT: if (cnt_q != '0 && !icap_busy) begin
        rdata_d = BIT_SWAP ? swap16(icap_o) : icap_o;
        state_d = RBACK_CE;
      end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
        rdata_d = '0;
        err_d   = 1'b1;
        state_d = RBACK_CE;
      end else cnt_d = cnt_q + CW'(1);
      RBACK_CE: state_d = RBACK_WR;
      RBACK_WR: begin
        state_d = DESYNC;
        cnt_d   = '0;
      end
      DESYNC: if (cnt_q == CW'(3)) state_d = DONE;
              else cnt_d = cnt_q + CW'(1);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    word         = 16'hFFFF;
    icap_ce_d    = 1'b1;
    icap_write_d = 1'b0;
    case (state_d)
      SYNC:     begin icap_ce_d = 1'b0; word = sync_word(cnt_d[1:0]); end
      HDR:      begin icap_ce_d = 1'b0; word = {3'b001, (wr_d ? 2'b10 : 2'b01), addr_d, 5'd1}; end
      WDATA:    begin icap_ce_d = 1'b0; word = wdata_d; end
      RPAD:     begin icap_ce_d = 1'b0; word = 16'h2000; end
      RMODE:    icap_write_d = 1'b1;
      RWAIT:    begin icap_ce_d = 1'b0; icap_write_d = 1'b1; end
      RBACK_CE: icap_write_d = 1'b1;
      DESYNC:   begin icap_ce_d = 1'b0; word = desync_word(cnt_d[1:0]); end
      default:  ;
    endcase
    icap_i_d    = BIT_SWAP ? swap16(word) : word;
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (state_d == DONE) begin
      rsp_rdata_d = wr_d ? 16'h0000 : rdata_d;
      rsp_err_d   = !wr_d && err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      icap_ce_q    <= 1'b1;
      icap_write_q <= 1'b0;
      icap_i_q     <= 16'hFFFF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      icap_ce_q    <= icap_ce_d;
      icap_write_q <= icap_write_d;
      icap_i_q     <= icap_i_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign icap_ce    = icap_ce_q;
  assign icap_write = icap_write_q;
  assign icap_i     = icap_i_q;

endmodule

// File: tb/tb_icap_s6_reg_access.sv
// Directed bench for icap_s6_reg_access: a straight-through instance and a
// byte-bit-swapped instance share all inputs; outputs are checked cycle by cycle.
module tb_icap_s6_reg_access;

  logic        clk, rst;
  logic        req_valid, req_write;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic [15:0] icap_o;
  logic        icap_busy;

  logic        req_ready, rsp_valid, rsp_err, icap_ce, icap_write;
  logic [15:0] rsp_rdata, icap_i;
  logic        req_ready_s, rsp_valid_s, rsp_err_s, icap_ce_s, icap_write_s;
  logic [15:0] rsp_rdata_s, icap_i_s;

  int n_chk  = 0;
  int n_pass = 0;

  icap_s6_reg_access #(.BIT_SWAP(1'b0), .NOOP_PAD(2), .TIMEOUT(64)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .icap_ce(icap_ce), .icap_write(icap_write), .icap_i(icap_i),
    .icap_o(icap_o), .icap_busy(icap_busy)
  );

  icap_s6_reg_access #(.BIT_SWAP(1'b1), .NOOP_PAD(2), .TIMEOUT(64)) dut_s (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready_s), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_s), .rsp_rdata(rsp_rdata_s), .rsp_err(rsp_err_s),
    .icap_ce(icap_ce_s), .icap_write(icap_write_s), .icap_i(icap_i_s),
    .icap_o(icap_o), .icap_busy(icap_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sticky flag: WRITE changing next to a CE-low cycle would abort the ICAP.
  logic prev_ce = 1'b1, prev_wr = 1'b0, abort_seen = 1'b0;
  always @(posedge clk) begin
    if (icap_write !== prev_wr && (icap_ce === 1'b0 || prev_ce === 1'b0))
      abort_seen <= 1'b1;
    prev_ce <= icap_ce;
    prev_wr <= icap_write;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] sync_w(input int i);
    case (i)
      0: return 16'hFFFF;
      1: return 16'hAA99;
      2: return 16'h5566;
      default: return 16'h2000;
    endcase
  endfunction

  function automatic logic [15:0] desync_w(input int i);
    case (i)
      0: return 16'h30A1;
      1: return 16'h000D;
      default: return 16'h2000;
    endcase
  endfunction

  // {req_ready, rsp_valid, icap_ce, icap_write, icap_i} expected n cycles after
  // acceptance of a read whose rsp_valid lands at cycle rn.
  function automatic logic [19:0] rd_exp(input int n, input int rn, input logic [15:0] hdr);
    logic ce, wr;
    logic [15:0] w;
    ce = 1'b1; wr = 1'b0; w = 16'hFFFF;
    if (n <= 4)               begin ce = 1'b0; w = sync_w(n - 1); end
    else if (n == 5)          begin ce = 1'b0; w = hdr; end
    else if (n <= 7)          begin ce = 1'b0; w = 16'h2000; end
    else if (n == 8)          ;
    else if (n == 9)          wr = 1'b1;
    else if (n <= rn - 7)     begin ce = 1'b0; wr = 1'b1; end
    else if (n == rn - 6)     wr = 1'b1;
    else if (n == rn - 5)     ;
    else                      begin ce = 1'b0; w = desync_w(n - (rn - 4)); end
    return {2'b00, ce, wr, w};
  endfunction

  function automatic logic [19:0] tup();
    return {req_ready, rsp_valid, icap_ce, icap_write, icap_i};
  endfunction

  task automatic do_write(input string tag, input logic [5:0] a, input logic [15:0] d,
                          input logic [0:9][15:0] e0, input logic [0:9][15:0] e1,
                          input bit use_s);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_write = 1'b1; req_addr = a; req_wdata = d; req_valid = 1'b1;
    tick;
    req_valid = 1'b0; req_wdata = 16'hDEAD; req_addr = 6'h3F;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_w%0d", tag, k), {12'd0, tup()}, {12'd0, 4'b0000, e0[k]});
      if (use_s) chk($sformatf("%s_sw%0d", tag, k), {16'd0, icap_i_s}, {16'd0, e1[k]});
      tick;
    end
    chk({tag, "_rsp"}, {12'd0, tup()}, {12'd0, 4'b0110, 16'hFFFF});
    chk({tag, "_rsp_data"}, {15'd0, rsp_err, rsp_rdata}, 32'd0);
    tick;
    chk({tag, "_idle"}, {12'd0, tup()}, {12'd0, 4'b1010, 16'hFFFF});
  endtask

  task automatic do_read(input string tag, input logic [5:0] a, input logic [15:0] hdr,
                         input int drop_n, input logic [15:0] o, input int rn,
                         input logic [15:0] exp_d, input logic exp_e,
                         input logic [15:0] exp_ds, input bit use_s);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    icap_busy = (drop_n == 0) ? 1'b0 : 1'b1;
    icap_o = o;
    req_write = 1'b0; req_addr = a; req_wdata = 16'h5A5A; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    for (int n = 1; n < rn; n++) begin
      chk($sformatf("%s_c%0d", tag, n), {12'd0, tup()}, {12'd0, rd_exp(n, rn, hdr)});
      if (n == drop_n) icap_busy = 1'b0;
      tick;
    end
    chk({tag, "_rsp"}, {12'd0, tup()}, {12'd0, 4'b0110, 16'hFFFF});
    chk({tag, "_rsp_data"}, {15'd0, rsp_err, rsp_rdata}, {15'd0, exp_e, exp_d});
    if (use_s) chk({tag, "_rsp_data_s"}, {16'd0, rsp_rdata_s}, {16'd0, exp_ds});
    tick;
    chk({tag, "_idle"}, {12'd0, tup()}, {12'd0, 4'b1010, 16'hFFFF});
    chk({tag, "_no_abort"}, {31'd0, abort_seen}, 32'd0);
    icap_busy = 1'b1;
  endtask

  initial begin
    int rsp_cnt, rdy_cnt, ce0_cnt;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    icap_o = 16'h0000; icap_busy = 1'b1;
    tick; tick; tick;

    // Reset state
    chk("rst_main", {12'd0, tup()}, {12'd0, 4'b0010, 16'hFFFF});
    chk("rst_rsp", {15'd0, rsp_err, rsp_rdata}, 32'd0);
    chk("rst_main_s", {12'd0, req_ready_s, rsp_valid_s, icap_ce_s, icap_write_s, icap_i_s},
        {12'd0, 4'b0010, 16'hFFFF});
    rst = 1'b0;
    tick;
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

    do_write("wr05", 6'h05, 16'h000E,
      {16'hFFFF, 16'hAA99, 16'h5566, 16'h2000, 16'h30A1, 16'h000E,
       16'h30A1, 16'h000D, 16'h2000, 16'h2000},
      {10{16'h0000}}, 1'b0);

    do_read("rd08", 6'h08, 16'h2901, 13, 16'h1234, 20, 16'h1234, 1'b0, 16'h0000, 1'b0);

    do_read("rd_to", 6'h0C, 16'h2981, -1, 16'hBEEF, 80, 16'h0000, 1'b1, 16'h0000, 1'b0);

    do_write("wr_sw", 6'h10, 16'h0180,
      {16'hFFFF, 16'hAA99, 16'h5566, 16'h2000, 16'h3201, 16'h0180,
       16'h30A1, 16'h000D, 16'h2000, 16'h2000},
      {16'hFFFF, 16'h5599, 16'hAA66, 16'h0400, 16'h4C80, 16'h8001,
       16'h0C85, 16'h00B0, 16'h0400, 16'h0400}, 1'b1);

    do_read("rd_sw", 6'h16, 16'h2AC1, 0, 16'h8001, 18, 16'h8001, 1'b0, 16'h0180, 1'b1);

    // Reset during the header word of a write
    req_write = 1'b1; req_addr = 6'h05; req_wdata = 16'h000E; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    for (int n = 1; n < 5; n++) tick;
    chk("rst_mid_hdr", {12'd0, tup()}, {12'd0, 4'b0000, 16'h30A1});
    rst = 1'b1;
    tick;
    chk("rst_mid_out", {12'd0, tup()}, {12'd0, 4'b0010, 16'hFFFF});
    chk("rst_mid_rsp", {15'd0, rsp_err, rsp_rdata}, 32'd0);
    rst = 1'b0;
    tick;
    chk("rst_mid_ready", {12'd0, tup()}, {12'd0, 4'b1010, 16'hFFFF});
    rsp_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      tick;
      if (rsp_valid === 1'b1 || icap_ce === 1'b0) rsp_cnt++;
    end
    chk("rst_mid_quiet", rsp_cnt, 0);

    // Back-to-back writes with req_valid held high
    req_write = 1'b1; req_addr = 6'h01; req_wdata = 16'h1111; req_valid = 1'b1;
    tick;
    req_addr = 6'h02; req_wdata = 16'h2222;
    rsp_cnt = 0; rdy_cnt = 0; ce0_cnt = 0;
    for (int n = 1; n <= 24; n++) begin
      if (rsp_valid === 1'b1) rsp_cnt++;
      if (req_ready === 1'b1) rdy_cnt++;
      if (icap_ce === 1'b0) ce0_cnt++;
      if (n == 5)  chk("b2b_hdr1", {16'd0, icap_i}, 32'h3021);
      if (n == 6)  chk("b2b_dat1", {16'd0, icap_i}, 32'h1111);
      if (n == 11) chk("b2b_rsp1", {31'd0, rsp_valid}, 32'd1);
      if (n == 12) chk("b2b_rdy", {12'd0, tup()}, {12'd0, 4'b1010, 16'hFFFF});
      if (n == 13) begin
        req_valid = 1'b0;
        chk("b2b_sync2", {12'd0, tup()}, {12'd0, 4'b0000, 16'hFFFF});
      end
      if (n == 17) chk("b2b_hdr2", {16'd0, icap_i}, 32'h3041);
      if (n == 18) chk("b2b_dat2", {16'd0, icap_i}, 32'h2222);
      if (n == 23) chk("b2b_rsp2", {31'd0, rsp_valid}, 32'd1);
      tick;
    end
    chk("b2b_rsp_count", rsp_cnt, 2);
    chk("b2b_ready_count", rdy_cnt, 2);
    chk("b2b_ce_words", ce0_cnt, 20);
    chk("final_no_abort", {31'd0, abort_seen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
